// File: rtl/mux_sel_gen.sv
// -----------------------------------------------------------------------------
// mux_sel_gen
//
// Select generator for one butterfly stage of the pipelined 1-D FFT data mux.
// A free-running frame counter defines a select window inside each frame.
// Inside the window, sel alternates between 0 and 1 in blocks of
// 2^HALF_LOG2 samples, starting with START_PHASE at window offset 0.
// Outside the window, sel carries the IDLE_SEL bypass code.
//
// All outputs except cnt_o are registered. They reflect the counter value
// of the previous cycle, and the instantiating stage absorbs this one-cycle
// latency through its choice of WIN_START.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (release is synchronous)
//   en          count enable; when low with sync low, counter and outputs hold
//   sync        frame resync; the counter reads 0 on the cycle after it is
//               sampled high (takes priority over en)
//   sel         registered mux select
//   win_active  registered; high while sel carries a window value
//   frame_last  registered one-cycle pulse for the last count of the frame
//   cnt_o       current frame counter value (debug / alignment)
// -----------------------------------------------------------------------------
module mux_sel_gen #(
    parameter int CNT_W       = 9,
    parameter int FRAME_LEN   = 257,
    parameter int WIN_START   = 125,
    parameter int WIN_LEN     = 128,
    parameter int HALF_LOG2   = 2,
    parameter int START_PHASE = 0,
    parameter int SEL_W       = 2,
    parameter int IDLE_SEL    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    output logic [SEL_W-1:0] sel,
    output logic             win_active,
    output logic             frame_last,
    output logic [CNT_W-1:0] cnt_o
);

    // -------------------------------------------------------------------------
    // Parameter sanity checks, reported at elaboration time.
    // -------------------------------------------------------------------------
    if (FRAME_LEN > (1 << CNT_W)) begin : g_chk_frame_len
        $error("mux_sel_gen: FRAME_LEN (%0d) does not fit in CNT_W (%0d) bits",
               FRAME_LEN, CNT_W);
    end

    if (WIN_START + WIN_LEN > FRAME_LEN) begin : g_chk_window
        $error("mux_sel_gen: window [%0d, %0d) extends past FRAME_LEN (%0d)",
               WIN_START, WIN_START + WIN_LEN, FRAME_LEN);
    end

    if (HALF_LOG2 >= CNT_W) begin : g_chk_half_log2
        $error("mux_sel_gen: HALF_LOG2 (%0d) must be below CNT_W (%0d)",
               HALF_LOG2, CNT_W);
    end

    if (IDLE_SEL <= 1) begin : g_chk_idle_sel
        $error("mux_sel_gen: IDLE_SEL (%0d) must differ from the window codes 0/1",
               IDLE_SEL);
    end

    if (IDLE_SEL >= (1 << SEL_W)) begin : g_chk_idle_width
        $error("mux_sel_gen: IDLE_SEL (%0d) does not fit in SEL_W (%0d) bits",
               IDLE_SEL, SEL_W);
    end

    if ((START_PHASE != 0) && (START_PHASE != 1)) begin : g_chk_start_phase
        $error("mux_sel_gen: START_PHASE (%0d) must be 0 or 1", START_PHASE);
    end

    // -------------------------------------------------------------------------
    // Constants sized to the datapath.
    // -------------------------------------------------------------------------
    localparam logic [CNT_W:0]   WIN_START_X   = (CNT_W + 1)'(WIN_START);
    localparam logic [CNT_W:0]   WIN_LEN_X     = (CNT_W + 1)'(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] PHASE_MASK    = CNT_W'(1) << HALF_LOG2;
    localparam logic             START_PHASE_B = (START_PHASE != 0);
    localparam logic [SEL_W-1:0] IDLE_C        = SEL_W'(IDLE_SEL);

    // -------------------------------------------------------------------------
    // Window decode (combinational on the current count)
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   off_x;
    logic [CNT_W-1:0] off;
    logic             in_win;
    logic             phase;
    logic             cnt_at_last;
    logic [SEL_W-1:0] sel_next;

    // The offset is formed one bit wider than the counter. Below WIN_START
    // the subtraction wraps to a value of at least 2^CNT_W, which is always
    // larger than WIN_LEN, so a single unsigned compare covers both window
    // edges. Because the window is checked against FRAME_LEN at elaboration,
    // its upper edge never needs to wrap around the frame.
    always_comb begin
        off_x       = {1'b0, cnt} - WIN_START_X;
        off         = off_x[CNT_W-1:0];
        in_win      = (off_x < WIN_LEN_X);
        phase       = (|(off & PHASE_MASK)) ^ START_PHASE_B;
        cnt_at_last = (cnt == CNT_LAST);
        sel_next    = in_win ? SEL_W'(phase) : IDLE_C;
    end

    // -------------------------------------------------------------------------
    // Frame counter and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            sel        <= IDLE_C;
            win_active <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            if (sync) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt_at_last ? '0 : cnt + CNT_ONE;
            end

            // On a resync cycle the outputs still decode the pre-resync count,
            // which keeps the select stream exactly one cycle behind cnt.
            if (en || sync) begin
                sel        <= sel_next;
                win_active <= in_win;
                frame_last <= cnt_at_last;
            end
        end
    end

    assign cnt_o = cnt;

endmodule
